// File: rtl/gcn_pkg.sv
// Shared constants, state encoding and address helper for the GCN scheduler.
// Imported by the bus interface, the loop counter and the scheduler top.
package gcn_pkg;

  localparam int FEATURE_ROWS          = 6;
  localparam int WEIGHT_COLS           = 3;
  localparam int COO_NUM_OF_COLS       = 6;
  localparam int ADDRESS_WIDTH         = 13;
  localparam int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS);
  localparam int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS);
  localparam int COO_BW                = $clog2(COO_NUM_OF_COLS);

  localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h200;

  typedef enum logic [2:0] {
    IDLE,
    RD_W,
    RD_F,
    MAC,
    WAIT,
    WRITE,
    AGG,
    DONE
  } gcn_sched_state_t;

  // Feature rows sit above the weight columns, so the two regions never alias.
  function automatic logic [ADDRESS_WIDTH-1:0] feature_addr(
    input logic [COUNTER_FEATURE_WIDTH-1:0] row
  );
    return FEATURE_BASE + ADDRESS_WIDTH'(row);
  endfunction

endpackage

// File: rtl/gcn_sched_if.sv
// Handshake bundle between the scheduler, the start/done pins and the datapath.
// master = scheduler side, slave = datapath / top-level side.
interface gcn_sched_if;
  import gcn_pkg::*;

  logic                             start;
  logic                             done;
  logic                             enable_read;
  logic [ADDRESS_WIDTH-1:0]         read_address;
  logic                             load_weight;
  logic                             load_feature;
  logic                             mac_start;
  logic                             mac_done;
  logic                             wr_en;
  logic [COUNTER_FEATURE_WIDTH-1:0] wr_row;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  wr_col;
  logic [COO_BW-1:0]                coo_address;
  logic                             agg_en;

  modport master (
    input  start, mac_done,
    output done, enable_read, read_address, load_weight, load_feature,
           mac_start, wr_en, wr_row, wr_col, coo_address, agg_en
  );

  modport slave (
    output start, mac_done,
    input  done, enable_read, read_address, load_weight, load_feature,
           mac_start, wr_en, wr_row, wr_col, coo_address, agg_en
  );

endinterface

// File: rtl/gcn_loop_counter.sv
// Saturating loop index: counts 0..LIMIT-1, flags the terminal value and never wraps.
// clear has priority over inc.
module gcn_loop_counter #(
  parameter int LIMIT = 4,
  parameter int WIDTH = $clog2(LIMIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             last
);

  assign last = (value == WIDTH'(LIMIT - 1));

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && !last) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/gcn_scheduler.sv
// GCN accelerator sequencer: walks every (row, col) dot product through the
// transform datapath, then every COO edge through aggregation, then raises done.
module gcn_scheduler
  import gcn_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  gcn_sched_if.master  bus
);

  gcn_sched_state_t state, state_next;

  logic [COUNTER_WEIGHT_WIDTH-1:0]  col;
  logic [COUNTER_FEATURE_WIDTH-1:0] row;
  logic [COO_BW-1:0]                edge_idx;
  logic col_last, row_last, edge_last;
  logic col_clear, col_inc, row_clear, row_inc, edge_clear, edge_inc;

  gcn_loop_counter #(.LIMIT(WEIGHT_COLS), .WIDTH(COUNTER_WEIGHT_WIDTH)) u_col (
    .clk(clk), .reset(reset), .clear(col_clear), .inc(col_inc),
    .value(col), .last(col_last)
  );

  gcn_loop_counter #(.LIMIT(FEATURE_ROWS), .WIDTH(COUNTER_FEATURE_WIDTH)) u_row (
    .clk(clk), .reset(reset), .clear(row_clear), .inc(row_inc),
    .value(row), .last(row_last)
  );

  gcn_loop_counter #(.LIMIT(COO_NUM_OF_COLS), .WIDTH(COO_BW)) u_edge (
    .clk(clk), .reset(reset), .clear(edge_clear), .inc(edge_inc),
    .value(edge_idx), .last(edge_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    col_clear  = 1'b0;
    col_inc    = 1'b0;
    row_clear  = 1'b0;
    row_inc    = 1'b0;
    edge_clear = 1'b0;
    edge_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          col_clear  = 1'b1;
          state_next = RD_W;
        end
      end
      RD_W: begin
        row_clear  = 1'b1;
        state_next = RD_F;
      end
      RD_F: state_next = MAC;
      MAC:  state_next = WAIT;
      WAIT: begin
        if (bus.mac_done) state_next = WRITE;
      end
      WRITE: begin
        if (!row_last) begin
          row_inc    = 1'b1;
          state_next = RD_F;
        end else if (!col_last) begin
          col_inc    = 1'b1;
          state_next = RD_W;
        end else begin
          edge_clear = 1'b1;
          state_next = AGG;
        end
      end
      AGG: begin
        if (edge_last) state_next = DONE;
        else           edge_inc   = 1'b1;
      end
      DONE: begin
        // A held start must not relaunch; the pin has to drop first.
        if (!bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: indices are gated to zero outside the state that uses them.
  always_comb begin
    bus.enable_read  = 1'b0;
    bus.read_address = '0;
    bus.load_weight  = 1'b0;
    bus.load_feature = 1'b0;
    bus.mac_start    = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_row       = '0;
    bus.wr_col       = '0;
    bus.coo_address  = '0;
    bus.agg_en       = 1'b0;
    bus.done         = 1'b0;
    case (state)
      RD_W: begin
        bus.enable_read  = 1'b1;
        bus.read_address = ADDRESS_WIDTH'(col);
        bus.load_weight  = 1'b1;
      end
      RD_F: begin
        bus.enable_read  = 1'b1;
        bus.read_address = feature_addr(row);
        bus.load_feature = 1'b1;
      end
      MAC:  bus.mac_start = 1'b1;
      WRITE: begin
        bus.wr_en  = 1'b1;
        bus.wr_row = row;
        bus.wr_col = col;
      end
      AGG: begin
        bus.agg_en      = 1'b1;
        bus.coo_address = edge_idx;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcn_scheduler.sv
// Self-checking bench for gcn_scheduler: a per-cycle expected schedule is
// built from the run description (rows x cols, random MAC latency, edges).
module tb_gcn_scheduler;

  localparam int ROWS  = 6;
  localparam int COLS  = 3;
  localparam int EDGES = 6;
  localparam logic [12:0] BASE = 13'h200;

  typedef struct packed {
    logic        enable_read;
    logic [12:0] read_address;
    logic        load_weight;
    logic        load_feature;
    logic        mac_start;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [1:0]  wr_col;
    logic [2:0]  coo_address;
    logic        agg_en;
    logic        done;
  } out_t;

  typedef struct {
    out_t exp;
    bit   ack;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  step_t sched[$];
  logic [15:0] coo_mem [8];
  logic [15:0] ref_edges[$];
  out_t obs;

  gcn_sched_if bus();

  gcn_scheduler dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.enable_read, bus.read_address, bus.load_weight, bus.load_feature,
                bus.mac_start, bus.wr_en, bus.wr_row, bus.wr_col, bus.coo_address,
                bus.agg_en, bus.done};

  task automatic check_out(input string tag, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input out_t o, input bit ack);
    step_t s;
    s.exp = o;
    s.ack = ack;
    sched.push_back(s);
  endtask

  // One entry per clock cycle, starting with the IDLE cycle that samples start.
  // Outside WAIT the mac_done input is noise (forced high during AGG).
  task automatic build(input int wmin, input int wmax, input bit held, output int abort_idx);
    out_t o;
    int   w;
    sched.delete();
    abort_idx = -1;
    push('0, 1'($urandom));
    for (int c = 0; c < COLS; c++) begin
      o = '0; o.enable_read = 1'b1; o.read_address = 13'(c); o.load_weight = 1'b1;
      push(o, 1'($urandom));
      for (int r = 0; r < ROWS; r++) begin
        o = '0; o.enable_read = 1'b1; o.read_address = BASE + 13'(r); o.load_feature = 1'b1;
        push(o, 1'($urandom));
        o = '0; o.mac_start = 1'b1;
        push(o, 1'($urandom));
        w = int'($urandom_range(wmax, wmin));
        for (int k = 0; k < w; k++) push('0, k == w - 1);
        o = '0; o.wr_en = 1'b1; o.wr_row = 3'(r); o.wr_col = 2'(c);
        if (r == 3 && c == 1) abort_idx = sched.size();
        push(o, 1'($urandom));
      end
    end
    for (int e = 0; e < EDGES; e++) begin
      o = '0; o.agg_en = 1'b1; o.coo_address = 3'(e);
      push(o, 1'b1);
    end
    o = '0; o.done = 1'b1;
    push(o, 1'($urandom));
    if (held) push(o, 1'($urandom));
    push('0, 1'($urandom));
  endtask

  // Precondition: called at a falling edge. Checks, then drives, each cycle.
  task automatic run_sched(input string tag, input int drop_idx, input int abort_idx,
                           input bit full, input bit check_edge82);
    int n_wr = 0;
    int n_mac = 0;
    int n_agg = 0;
    int first_done = -1;
    logic [15:0] got[$];
    for (int i = 0; i < sched.size(); i++) begin
      check_out($sformatf("%s step %0d", tag, i), sched[i].exp);
      if (obs.wr_en)     n_wr++;
      if (obs.mac_start) n_mac++;
      if (obs.agg_en) begin
        n_agg++;
        got.push_back(coo_mem[obs.coo_address]);
      end
      if (obs.done && first_done < 0) first_done = i;
      if (i == abort_idx) begin
        #2 reset = 1'b0;
        #1 check_out({tag, " async abort"}, '0);
        return;
      end
      bus.start    = (i < drop_idx);
      bus.mac_done = sched[i].ack;
      @(negedge clk);
    end
    if (full) begin
      check_int({tag, " wr_en count"}, n_wr, ROWS * COLS);
      check_int({tag, " mac_start count"}, n_mac, ROWS * COLS);
      check_int({tag, " agg_en count"}, n_agg, EDGES);
      check_int({tag, " edge list size"}, got.size(), ref_edges.size());
      for (int k = 0; k < got.size() && k < ref_edges.size(); k++)
        check_int($sformatf("%s edge %0d", tag, k), int'(got[k]), int'(ref_edges[k]));
    end
    if (check_edge82) check_int({tag, " done edge"}, first_done, 82);
  endtask

  initial begin
    int abort_idx;
    int dummy;
    for (int k = 0; k < 8; k++) coo_mem[k] = 16'($urandom);
    for (int e = 0; e < EDGES; e++) ref_edges.push_back(coo_mem[e]);

    // Reset held low with start asserted: everything stays zero.
    bus.start    = 1'b1;
    bus.mac_done = 1'b0;
    reset        = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_out($sformatf("reset hold %0d", k), '0);
    end
    reset = 1'b1;

    // Single-cycle MAC latency, start held through DONE: done at edge 82.
    build(1, 1, 1'b1, dummy);
    run_sched("w1 held", sched.size() - 2, -1, 1'b1, 1'b1);

    // Random MAC latency, start held.
    build(1, 6, 1'b1, dummy);
    run_sched("wrand held", sched.size() - 2, -1, 1'b1, 1'b0);

    // Fixed five-cycle MAC latency, start dropped early in the run.
    build(5, 5, 1'b0, dummy);
    run_sched("w5 drop", 20, -1, 1'b1, 1'b0);

    // Abort with reset during WRITE of (3,1), then restart from scratch.
    build(1, 3, 1'b1, abort_idx);
    run_sched("abort", sched.size() - 2, abort_idx, 1'b0, 1'b0);
    bus.start    = 1'b1;
    bus.mac_done = 1'b0;
    @(negedge clk);
    check_out("reset after abort", '0);
    reset = 1'b1;
    build(1, 4, 1'b0, dummy);
    run_sched("restart", 33, -1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
